csa_resolver: RTL
=================

// Module: csa_resolver
// PURPOSE
// - Consumer end of the carry-save datapath: accepts one redundant (sum, carry) vector pair
//   and resolves it to a plain binary result.
// - Uses a multi-cycle chunked carry-propagate adder: CHUNK bits per clock, one carry flop
//   between chunks.
// - Sits after a carry-save adder stage. Valid/ready handshake on both sides.
// PARAMETERS
// - WIDTH  10  width of in_sum / in_carry
// - CHUNK  4   bits resolved per cycle; (WIDTH+2) % CHUNK must be 0 (elaboration $error otherwise)
// - NCH    (WIDTH+2)/CHUNK  derived localparam, number of chunk cycles
// PORTS
// - clk         in   1        single clock, rising edge
// - rst_n       in   1        asynchronous active-low reset
// - in_valid    in   1        input pair valid
// - in_ready    out  1        block can accept a pair
// - in_sum      in   WIDTH    sum vector; bit i has weight 2^i
// - in_carry    in   WIDTH    carry vector; bit i has weight 2^(i+1)
// - out_valid   out  1        out_result valid
// - out_ready   in   1        downstream accepts result
// - out_result  out  WIDTH+2  in_sum + 2*in_carry, zero-extended, no truncation
// - busy        out  1        high in ADD or DONE
// BEHAVIOUR
// - Reset (async assert, sync deassert by the system): state=IDLE, in_ready=0 during reset,
//   then 1 in IDLE; out_valid=0; out_result=0; busy=0; chunk index=0; carry flop=0.
// - Operands: A={2'b0,in_sum}, B={1'b0,in_carry,1'b0}, both WIDTH+2 bits.
//   Operands are captured at acceptance.
// - Acceptance: edge where in_valid && in_ready. in_ready=1 only in IDLE.
// - FSM: IDLE -> ADD on acceptance.
// - FSM: ADD. On each edge, chunk k = A[k*CHUNK+:CHUNK] + B[k*CHUNK+:CHUNK] + cflop is written
//   into out_result[k*CHUNK+:CHUNK], cflop <= carry out, k++.
//   After chunk NCH-1: -> DONE, k=0, cflop=0.
// - FSM: DONE. out_valid=1 and out_result is held stable until out_ready.
//   On out_valid && out_ready: -> IDLE, out_valid=0.
// - Latency: out_valid rises NCH edges after the accept edge (3 at defaults).
//   Minimum spacing between accepts is NCH+2 cycles with out_ready tied high.
// - No overlap: a new pair is never accepted in the same cycle a result is handed off.
// - The final carry out of chunk NCH-1 is always 0 by range; it is discarded.
// - Max result: 3*(2^WIDTH-1).
// - Inputs while in_ready=0: ignored and not sampled.
// - out_ready while out_valid=0: ignored.
// - Reset mid-ADD or mid-DONE: partial result discarded, all state returns to reset values,
//   no out_valid pulse.
// - out_result is undefined to consumers unless out_valid=1.
//   RTL still clears it on reset and does not clear it on hand-off.
// CONFIGURATION
// - CSA_RES_ZERO_BYPASS_EN defined: if in_carry==0 at acceptance, out_result<={2'b0,in_sum} and
//   IDLE -> DONE directly. out_valid is then visible 1 edge after accept.
//   Nonzero carry uses the normal ADD path.
// - CSA_RES_ZERO_BYPASS_EN undefined: every pair takes the full NCH-cycle ADD path,
//   including carry==0.
// TESTING (WIDTH=10, CHUNK=4)
// - Reset: hold rst_n=0 -> out_valid=0, busy=0, out_result=0.
//   Release -> in_ready=1 next cycle.
// - Basic: sum=0x155, carry=0x0AA, out_ready=1 -> out_result=0x2A9, out_valid exactly 3 edges
//   after accept, for 1 cycle.
// - Max: sum=0x3FF, carry=0x3FF -> out_result=0xBFD. Full carry chain ripples across all
//   3 chunks.
// - Backpressure: out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0,
//   a new in_valid is ignored. Raising out_ready -> hand-off, in_ready=1 next cycle.
// - Reset mid-op: assert rst_n=0 one edge after accept of sum=0x3FF, carry=0x001 -> no
//   out_valid. A subsequent sum=0x001, carry=0x001 yields 0x003.
// - Bypass: sum=0x123, carry=0 -> 0x123 after 1 edge with macro defined, after 3 edges without.

Source files
------------

// File: rtl/csa_resolver_if.sv
// Handshake bundle between a carry-save producer and csa_resolver.
// The master side drives the operand pair and accepts the resolved result.
interface csa_resolver_if #(
    parameter int unsigned WIDTH = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] out_result;
    logic             busy;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/csa_resolver.sv
// Resolves one carry-save (sum, carry) pair to binary with a CHUNK-bit-per-cycle adder.
// Optional feature: define CSA_RES_ZERO_BYPASS_EN to skip the adder when carry is zero.
module csa_resolver #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CHUNK = 4
) (
    input logic           clk,
    input logic           rst_n,
    csa_resolver_if.slave bus
);
    localparam int unsigned RW  = WIDTH + 2;
    localparam int unsigned NCH = RW / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

    if ((RW % CHUNK) != 0) begin : g_bad_chunk
        $error("csa_resolver: (WIDTH+2) must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [KW-1:0]   k_q, k_d;
    logic            cflop_q, cflop_d;
    logic            rdy_q;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]  chunk_sum;
    logic            accept;

    assign accept = bus.in_valid && rdy_q;

    // Constant-index mux keeps the chunk select free of variable part-selects.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, cflop_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        k_d     = k_q;
        cflop_d = cflop_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d = {2'b00, bus.in_sum};
                    b_d = {1'b0, bus.in_carry, 1'b0};
`ifdef CSA_RES_ZERO_BYPASS_EN
                    if (bus.in_carry == '0) begin
                        res_d   = {2'b00, bus.in_sum};
                        state_d = StDone;
                    end else begin
                        state_d = StAdd;
                    end
`else
                    state_d = StAdd;
`endif
                end
            end
            StAdd: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (k_q == KW'(i)) res_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                end
                // Top chunk's carry out is always zero by operand range; drop it.
                if (k_q == KW'(NCH - 1)) begin
                    state_d = StDone;
                    k_d     = '0;
                    cflop_d = 1'b0;
                end else begin
                    k_d     = k_q + 1'b1;
                    cflop_d = chunk_sum[CHUNK];
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            k_q     <= '0;
            cflop_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            k_q     <= k_d;
            cflop_q <= cflop_d;
            rdy_q   <= (state_d == StIdle);
        end
    end

    assign bus.in_ready   = rdy_q;
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_result = res_q;
    assign bus.busy       = (state_q != StIdle);
endmodule
